// File: rtl/usb_pkt_fifo.sv
// ---------------------------------------------------------------------------
// usb_pkt_fifo
//   Synchronous packet FIFO with commit/discard semantics. The write side
//   fills an "open" packet speculatively. The packet then either becomes
//   visible to the reader (commit) or is thrown away (discard, or commit of a
//   packet that overflowed). The reader therefore only ever sees complete,
//   good packets.
//
// Ports
//   clk, rst      : clock (rising edge) and asynchronous active-high reset
//   w_data, wr_en : write one word into the open packet
//   wr_commit     : publish the open packet to the reader
//   wr_discard    : drop the open packet (wins over wr_commit)
//   rd_en         : pop one committed word
//   r_data/r_valid: registered read data; r_valid marks a pop from last cycle
//   flag_full     : committed + speculative occupancy == DEPTH
//   flag_empty    : no committed word available
//   flag_afull    : total occupancy >= AFULL_LVL
//   flag_aempty   : committed count <= AEMPTY_LVL
//   count         : committed words available to the reader
//   pkt_dropped   : one-cycle pulse when a packet is closed without commit
//   err_underflow : one-cycle pulse on rd_en while empty
// ---------------------------------------------------------------------------
module usb_pkt_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int AFULL_LVL  = DEPTH - 4,
  parameter int AEMPTY_LVL = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     w_data,
  input  logic                      wr_en,
  input  logic                      wr_commit,
  input  logic                      wr_discard,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     r_data,
  output logic                      r_valid,
  output logic                      flag_full,
  output logic                      flag_empty,
  output logic                      flag_afull,
  output logic                      flag_aempty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      pkt_dropped,
  output logic                      err_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_LVL);
  localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_LVL);

  logic [DATA_WIDTH-1:0] storage [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr_c;   // end of committed data
  logic [AW:0] wr_ptr_s;   // end of speculative (open packet) data
  logic        ovf;        // open packet lost at least one word

  logic [AW:0] used;
  logic        ovf_hit;
  logic        close_drop;
  logic        close_keep;
  logic        do_write;
  logic        do_read;
  logic [AW:0] wr_ptr_s_inc;

  assign used        = wr_ptr_s - rd_ptr;
  assign count       = wr_ptr_c - rd_ptr;
  assign flag_full   = (used == FULL_C);
  assign flag_empty  = (wr_ptr_c == rd_ptr);
  assign flag_afull  = (used >= AFULL_C);
  assign flag_aempty = (count <= AEMPTY_C);

  // A word arriving while full is lost; that taints the packet even if the
  // commit comes in the very same cycle.
  assign ovf_hit    = wr_en && flag_full;
  assign close_drop = wr_discard || (wr_commit && (ovf || ovf_hit));
  assign close_keep = wr_commit && !close_drop;
  assign do_write   = wr_en && !flag_full && !close_drop;
  assign do_read    = rd_en && !flag_empty;

  // Commit includes a word written in the same cycle.
  assign wr_ptr_s_inc = wr_ptr_s + (AW+1)'(do_write);

  // Storage array without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_write) begin
      storage[wr_ptr_s[AW-1:0]] <= w_data;
    end
  end

  // Write side pointers and packet state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_s    <= '0;
      wr_ptr_c    <= '0;
      ovf         <= 1'b0;
      pkt_dropped <= 1'b0;
    end else begin
      pkt_dropped <= close_drop;
      if (close_drop) begin
        wr_ptr_s <= wr_ptr_c;
        ovf      <= 1'b0;
      end else if (close_keep) begin
        wr_ptr_s <= wr_ptr_s_inc;
        wr_ptr_c <= wr_ptr_s_inc;
        ovf      <= 1'b0;
      end else begin
        wr_ptr_s <= wr_ptr_s_inc;
        if (ovf_hit) begin
          ovf <= 1'b1;
        end
      end
    end
  end

  // Read side: one-cycle latency, r_data holds when nothing is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr        <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      r_valid       <= do_read;
      err_underflow <= rd_en && flag_empty;
      if (do_read) begin
        r_data <= storage[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_usb_pkt_fifo.sv
// ---------------------------------------------------------------------------
// tb_usb_pkt_fifo
//   Directed bench for usb_pkt_fifo (DEPTH=16). Stimulus pushes the expected
//   read data into a queue whenever it issues a read that should return a
//   word; a separate monitor pops and compares on every r_valid cycle.
//   Flags, count and pulses are checked right after the relevant edge.
// ---------------------------------------------------------------------------
module tb_usb_pkt_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] w_data = '0;
  logic          wr_en = 1'b0;
  logic          wr_commit = 1'b0;
  logic          wr_discard = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          flag_full;
  logic          flag_empty;
  logic          flag_afull;
  logic          flag_aempty;
  logic [CW-1:0] count;
  logic          pkt_dropped;
  logic          err_underflow;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q [$];

  usb_pkt_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .AFULL_LVL(DEPTH - 4),
    .AEMPTY_LVL(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .w_data(w_data),
    .wr_en(wr_en),
    .wr_commit(wr_commit),
    .wr_discard(wr_discard),
    .rd_en(rd_en),
    .r_data(r_data),
    .r_valid(r_valid),
    .flag_full(flag_full),
    .flag_empty(flag_empty),
    .flag_afull(flag_afull),
    .flag_aempty(flag_aempty),
    .count(count),
    .pkt_dropped(pkt_dropped),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("[TB] ok   %s: 0x%0h", name, act);
    end
  endtask

  // One clock cycle with the given controls; returns 1 time unit after the edge.
  task automatic cyc(input logic we, input logic [DW-1:0] d, input logic cm,
                     input logic dc, input logic re);
    wr_en = we;
    w_data = d;
    wr_commit = cm;
    wr_discard = dc;
    rd_en = re;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    wr_commit = 1'b0;
    wr_discard = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [DW-1:0] exp);
    exp_q.push_back(exp);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: samples on the falling edge.
  always @(negedge clk) begin
    if (!rst && r_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_rvalid", 1, 0);
      end else begin
        chk("sb_rdata", int'(r_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    int max_cnt;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_empty", int'(flag_empty), 1);
    chk("rst_full", int'(flag_full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_aempty", int'(flag_aempty), 1);
    chk("rst_afull", int'(flag_afull), 0);
    chk("rst_rvalid", int'(r_valid), 0);
    chk("rst_rdata", int'(r_data), 0);

    // 5 bytes, commit, read back
    for (int i = 1; i <= 5; i++) wr(DW'(i));
    chk("t1_empty_before_commit", int'(flag_empty), 1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t1_count", int'(count), 5);
    chk("t1_empty", int'(flag_empty), 0);
    for (int i = 1; i <= 5; i++) begin
      rd(DW'(i));
      chk("t1_count_dec", int'(count), 5 - i);
      chk("t1_no_underflow", int'(err_underflow), 0);
    end
    chk("t1_empty_after", int'(flag_empty), 1);
    idle();

    // Speculative write, discard, then a single good packet
    wr(8'h11); wr(8'h12); wr(8'h13);
    chk("t2_empty_spec", int'(flag_empty), 1);
    chk("t2_count_spec", int'(count), 0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("t2_dropped", int'(pkt_dropped), 1);
    idle();
    chk("t2_dropped_clear", int'(pkt_dropped), 0);
    wr(8'hAA);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t2_count", int'(count), 1);
    rd(8'hAA);
    idle();

    // Overflow: 16 words fill, 17th lost, commit acts as discard
    for (int i = 0; i < 16; i++) begin
      wr(DW'(8'h20 + i));
      if (i == 14) chk("t3_not_full_15", int'(flag_full), 0);
    end
    chk("t3_full", int'(flag_full), 1);
    chk("t3_afull", int'(flag_afull), 1);
    wr(8'hFF);
    chk("t3_full_17", int'(flag_full), 1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t3_dropped", int'(pkt_dropped), 1);
    chk("t3_count", int'(count), 0);
    chk("t3_full_after", int'(flag_full), 0);
    chk("t3_empty_after", int'(flag_empty), 1);
    idle();
    chk("t3_dropped_clear", int'(pkt_dropped), 0);

    // Pointer wrap: 10 x (write 12 / commit / read 12)
    max_cnt = 0;
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < 12; k++) wr(DW'(it * 12 + k + 8'h40));
      if (it == 0) chk("t4_afull_12", int'(flag_afull), 1);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("t4_count_commit", int'(count), 12);
      if (it == 0) chk("t4_aempty_12", int'(flag_aempty), 0);
      for (int k = 0; k < 12; k++) begin
        rd(DW'(it * 12 + k + 8'h40));
        if (int'(count) > max_cnt) max_cnt = int'(count);
      end
      chk("t4_count_drained", int'(count), 0);
    end
    chk("t4_max_count", max_cnt, 11);
    idle();

    // Same-cycle write+commit, then commit+discard with committed data held
    wr(8'h7C); wr(8'h7D);
    cyc(1'b1, 8'h7E, 1'b1, 1'b0, 1'b0);
    chk("t5_count_wc", int'(count), 3);
    wr(8'h90); wr(8'h91);
    cyc(1'b1, 8'h92, 1'b1, 1'b1, 1'b0);
    chk("t5_dropped", int'(pkt_dropped), 1);
    chk("t5_count_unchanged", int'(count), 3);
    v = 8'h7C;
    for (int k = 0; k < 3; k++) begin
      rd(v);
      v = v + 1'b1;
    end
    chk("t5_empty", int'(flag_empty), 1);
    idle();

    // Reset mid-packet: 8 committed, 3 speculative
    for (int i = 0; i < 8; i++) wr(DW'(8'hC0 + i));
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    wr(8'hD0); wr(8'hD1); wr(8'hD2);
    chk("t6_count_pre", int'(count), 8);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_count_async", int'(count), 0);
    @(posedge clk);
    #1;
    chk("t6_count", int'(count), 0);
    chk("t6_empty", int'(flag_empty), 1);
    chk("t6_rvalid", int'(r_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t6_underflow", int'(err_underflow), 1);
    chk("t6_rvalid_uf", int'(r_valid), 0);
    idle();
    chk("t6_underflow_clear", int'(err_underflow), 0);
    idle();

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/usb_pkt_fifo.md
# usb_pkt_fifo

Parametrised synchronous packet FIFO with commit/discard semantics, the successor to the hub's plain byte FIFO. The receive path writes a USB packet speculatively, then either commits it (CRC/PID good) or discards it (error, babble, overflow), so the read side only ever sees complete, good packets. It adds configurable depth/width, level count, almost-full/almost-empty thresholds and overflow/underflow reporting. Sits between the SIE receive datapath and the downstream-port forwarding logic, one instance per direction.

## Interface

- DATA_WIDTH, 8, word width in bits
- DEPTH, 64, number of words; power of two, >= 4
- AFULL_LVL, DEPTH-4, flag_afull asserts when free words <= DEPTH-AFULL_LVL (i.e. total occupancy >= AFULL_LVL)
- AEMPTY_LVL, 4, flag_aempty asserts when committed count <= AEMPTY_LVL

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- w_data  in  DATA_WIDTH  write data
- wr_en  in  1  write one word into the open packet
- wr_commit  in  1  make all words of the open packet visible to the reader
- wr_discard  in  1  drop all words of the open packet
- rd_en  in  1  read one committed word
- r_data  out  DATA_WIDTH  read data, registered
- r_valid  out  1  r_data holds a word popped by the previous-cycle rd_en
- flag_full  out  1  no free slot (committed + uncommitted = DEPTH)
- flag_empty  out  1  no committed word available
- flag_afull  out  1  total occupancy >= AFULL_LVL
- flag_aempty  out  1  committed count <= AEMPTY_LVL
- count  out  log2(DEPTH)+1  committed words available to reader
- pkt_dropped  out  1  one-cycle pulse: packet closed by discard or by commit of an overflowed packet
- err_underflow  out  1  one-cycle pulse: rd_en while flag_empty

## Operation

- Pointers log2(DEPTH)+1 bits (wrap bit): rd_ptr, wr_ptr_c (committed), wr_ptr_s (speculative). Full: wr_ptr_s - rd_ptr == DEPTH. Empty: wr_ptr_c == rd_ptr. count = wr_ptr_c - rd_ptr, modulo 2^(log2(DEPTH)+1).
- Write: wr_en && !flag_full -> storage[wr_ptr_s] <= w_data, wr_ptr_s++. wr_en && flag_full -> word dropped, sticky ovf bit set for open packet.
- Commit: wr_commit, ovf clear -> wr_ptr_c <= wr_ptr_s (including a word written the same cycle). ovf set -> treated as discard.
- Discard: wr_ptr_s <= wr_ptr_c, ovf cleared, pkt_dropped pulses. wr_commit and wr_discard together -> discard wins; a same-cycle wr_en word is also dropped.
- Read: rd_en && !flag_empty -> r_data <= storage[rd_ptr], rd_ptr++, r_valid <= 1. Otherwise r_valid <= 0, r_data holds. rd_en && flag_empty -> err_underflow pulse, no pointer change.
- Read and write/commit/discard in the same cycle are independent; reads never touch speculative data.
- Empty commit (no words since last close) is legal, no effect except clearing ovf state.
- Reset (any time, including mid-packet): all pointers 0, ovf 0, r_data 0, r_valid 0, pkt_dropped 0, err_underflow 0; hence flag_empty 1, flag_full 0, count 0, flag_aempty 1, flag_afull 0. Storage contents not reset.

## Timing

- All flags and count are combinational from registered pointers; they change only after a clock edge.
- Commit at edge N -> flag_empty/count update visible in cycle N+1; earliest rd_en of that data in N+1, r_data/r_valid after edge N+1.
- Read latency 1 cycle; back-to-back rd_en gives one word per cycle.
- Read at edge N frees the slot: flag_full may deassert in cycle N+1.
- pkt_dropped and err_underflow are registered, asserted for exactly the cycle after the triggering edge.

## Test plan

- DEPTH=16, write 5 bytes 0x01..0x05, commit, read 5 -> r_data 0x01..0x05 on consecutive cycles with r_valid=1; count 5->0; flag_empty=1 after last; no err_underflow.
- Write 3 bytes, no commit -> flag_empty stays 1, count 0; discard -> pkt_dropped one cycle; then write 0xAA, commit -> single read returns 0xAA.
- Write 16 bytes then a 17th, commit -> flag_full=1 after 16th; 17th dropped, commit acts as discard, pkt_dropped pulses, count 0.
- Pointer wrap: 10 cycles of write 12/commit/read 12 -> data order preserved through multiple wraps; count never exceeds 12.
- Same-cycle wr_en+wr_commit with last byte 0x7E -> 0x7E included; same-cycle wr_commit+wr_discard -> packet dropped, count unchanged.
- Assert rst mid-packet with 8 committed, 3 speculative -> next cycle count 0, flag_empty 1, r_valid 0; rd_en -> err_underflow pulse.
